// File: rtl/ring_meter_pkg.sv
// Shared types for the ring-oscillator frequency meter.
// Holds the measurement FSM encoding and the mode select constants.
package ring_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATE    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/edge_sync.sv
// Brings one asynchronous ring output into the clk domain and emits a one-cycle rising-edge pulse.
// Latency: ring edge to pulse is 3 cycles (two sync flops plus a registered detector).
module edge_sync
  import ring_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q, pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ring_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts synchronized rising edges over a gate window.
// Results leave through a valid/ready port; an unaccepted result that gets overwritten raises sticky overrun.
module ring_freq_meter
  import ring_meter_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   mode,
  input  logic [GATE_W-1:0]      gate_len,
  input  logic [N_CH-1:0]        ring_in,
  output logic                   busy,
  output logic [N_CH*CNT_W-1:0]  value_out,
  output logic [N_CH-1:0]        sat,
  output logic                   valid,
  input  logic                   ready,
  output logic                   overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                       state_q, state_d;
  logic [GATE_W-1:0]            len_q, len_d;
  logic [GATE_W-1:0]            gcnt_q, gcnt_d;
  logic [N_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CH*CNT_W-1:0]        value_q, value_d;
  logic [N_CH-1:0]              sat_q, sat_d;
  logic                         valid_q, valid_d;
  logic                         overrun_q, overrun_d;
  logic [N_CH-1:0]              pulse;
  logic                         launch, capture, start_acc, handshake;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    edge_sync u_edge_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (ring_in[i]),
      .pulse_o (pulse[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    capture   = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (start || mode == MODE_CONT)) begin
          state_d   = GATE;
          launch    = 1'b1;
          start_acc = start;
        end
      end
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (gcnt_q == len_q - GATE_W'(1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          if (mode == MODE_CONT) begin
            state_d = GATE;
            launch  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window counters: an abort clears everything, a launch re-arms with the new length.
  always_comb begin
    len_d  = len_q;
    gcnt_d = gcnt_q;
    cnt_d  = cnt_q;
    if (!enable) begin
      gcnt_d = '0;
      cnt_d  = '0;
    end else if (launch) begin
      len_d  = (gate_len == '0) ? GATE_W'(1) : gate_len;
      gcnt_d = '0;
      cnt_d  = '0;
    end else if (state_q == GATE) begin
      gcnt_d = gcnt_q + GATE_W'(1);
      for (int i = 0; i < N_CH; i++) begin
        if (pulse[i] && cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign handshake = valid_q & ready;

  // A capture always wins over a coincident handshake; overrun only sets if the old result was not taken.
  always_comb begin
    value_d   = value_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (capture) begin
      value_d = cnt_q;
      for (int i = 0; i < N_CH; i++) begin
        sat_d[i] = (cnt_q[i] == CNT_MAX);
      end
      valid_d = 1'b1;
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end
    end else begin
      if (handshake) begin
        valid_d   = 1'b0;
        overrun_d = 1'b0;
      end
      if (start_acc) begin
        overrun_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= GATE_W'(1);
      gcnt_q    <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      sat_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      gcnt_q    <= gcnt_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign value_out = value_q;
  assign sat       = sat_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: a wide-counter and a 4-bit-counter instance share all stimulus.
// A window-arithmetic model predicts every output each cycle; literal checks pin the key scenarios.
module tb_ring_freq_meter;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 16;
  localparam int GATE_W = 16;
  localparam int SW     = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  enable = 1'b0, start = 1'b0, mode = 1'b0, ready = 1'b0;
  logic [GATE_W-1:0]     gate_len = '0;
  logic [N_CH-1:0]       ring_in = '0;
  logic                  busy, valid, overrun;
  logic [N_CH*CNT_W-1:0] value_out;
  logic [N_CH-1:0]       sat;
  logic                  busy_s, valid_s, overrun_s;
  logic [N_CH*SW-1:0]    value_s;
  logic [N_CH-1:0]       sat_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ring_freq_meter #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .mode(mode),
    .gate_len(gate_len), .ring_in(ring_in), .busy(busy), .value_out(value_out),
    .sat(sat), .valid(valid), .ready(ready), .overrun(overrun)
  );

  ring_freq_meter #(.N_CH(N_CH), .CNT_W(SW), .GATE_W(GATE_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .mode(mode),
    .gate_len(gate_len), .ring_in(ring_in), .busy(busy_s), .value_out(value_s),
    .sat(sat_s), .valid(valid_s), .ready(ready), .overrun(overrun_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int clip(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v >= mx) ? mx : v;
  endfunction

  // Ring stimulus: square waves with programmable high/low lengths in whole clk cycles.
  int hi_len[N_CH], lo_len[N_CH], ph[N_CH];
  bit ring_on = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (!ring_on) begin
          ring_in[ch] = 1'b0;
          ph[ch] = 0;
        end else begin
          ph[ch]++;
          if (ring_in[ch] ? (ph[ch] >= hi_len[ch]) : (ph[ch] >= lo_len[ch])) begin
            ring_in[ch] = ~ring_in[ch];
            ph[ch] = 0;
          end
        end
      end
    end
  end

  // Model: cycle c is a GATE cycle iff wf <= c <= wl of the open window, CAPTURE iff c == wl+1.
  // A ring rise first seen in cycle c (r[c]=1, r[c-1]=0) yields a pulse in cycle c+3.
  int             mc = 0;
  int             m_prev;
  bit             act = 1'b0;
  int             wf, wl;
  int             mcnt[N_CH];
  int             m_raw[N_CH];
  bit             m_valid = 1'b0, m_ovr = 1'b0;
  bit [N_CH-1:0]  rh[8];
  bit [N_CH-1:0]  m_pulse;
  bit             was_gate, was_cap, hs, captured;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act = 1'b0;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        mcnt[i] = 0;
        m_raw[i] = 0;
      end
      for (int k = 0; k < 8; k++) rh[k] = '0;
    end else begin
      m_prev = mc;
      mc = mc + 1;
      rh[m_prev % 8] = ring_in;
      m_pulse = rh[(m_prev + 5) % 8] & ~rh[(m_prev + 4) % 8];
      was_gate = act && m_prev >= wf && m_prev <= wl;
      was_cap  = act && m_prev == wl + 1;
      hs = m_valid && ready;
      captured = 1'b0;
      if (was_gate)
        for (int i = 0; i < N_CH; i++) if (m_pulse[i]) mcnt[i]++;
      if (!enable) begin
        act = 1'b0;
      end else if (was_cap || !act) begin
        if (was_cap) begin
          for (int i = 0; i < N_CH; i++) m_raw[i] = mcnt[i];
          if (m_valid && !ready) m_ovr = 1'b1;
          m_valid = 1'b1;
          captured = 1'b1;
        end else if (start) begin
          m_ovr = 1'b0;
        end
        if (mode || (!was_cap && start)) begin
          wf = mc;
          wl = mc + ((gate_len == 0) ? 1 : int'(gate_len)) - 1;
          act = 1'b1;
          for (int i = 0; i < N_CH; i++) mcnt[i] = 0;
        end else begin
          act = 1'b0;
        end
      end
      if (!captured && hs) begin
        m_valid = 1'b0;
        m_ovr = 1'b0;
      end
    end
  end

  logic [63:0]        ev;
  logic [N_CH*SW-1:0] evs;
  logic [N_CH-1:0]    es, ess;

  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      ev[i*CNT_W +: CNT_W] = CNT_W'(clip(m_raw[i], CNT_W));
      es[i]  = (m_raw[i] >= (1 << CNT_W) - 1);
      evs[i*SW +: SW] = SW'(clip(m_raw[i], SW));
      ess[i] = (m_raw[i] >= (1 << SW) - 1);
    end
    chk("busy", 64'(busy), 64'(act));
    chk("valid", 64'(valid), 64'(m_valid));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("value_out", value_out, ev);
    chk("sat", 64'(sat), 64'(es));
    chk("busy_s", 64'(busy_s), 64'(act));
    chk("valid_s", 64'(valid_s), 64'(m_valid));
    chk("overrun_s", 64'(overrun_s), 64'(m_ovr));
    chk("value_s", 64'(value_s), 64'(evs));
    chk("sat_s", 64'(sat_s), 64'(ess));
  end

  int k, pulses;

  initial begin
    for (int ch = 0; ch < N_CH; ch++) begin
      hi_len[ch] = 1;
      lo_len[ch] = 1;
    end
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_value", value_out, 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    #1 rst_n = 1'b1;

    // Single-shot, ring periods 4/8/10/20, L=100.
    hi_len[0] = 2;  lo_len[0] = 2;
    hi_len[1] = 4;  lo_len[1] = 4;
    hi_len[2] = 5;  lo_len[2] = 5;
    hi_len[3] = 10; lo_len[3] = 10;
    ring_on = 1'b1;
    enable = 1'b1;
    gate_len = 16'd100;
    repeat (30) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("ss_valid_t101", 64'(valid), 64'd0);
    @(negedge clk);
    chk("ss_valid_t102", 64'(valid), 64'd1);
    chk_range("ss_ch0", int'(value_out[0 +: 16]), 24, 26);
    chk_range("ss_ch1", int'(value_out[16 +: 16]), 11, 13);
    chk_range("ss_ch2", int'(value_out[32 +: 16]), 9, 11);
    chk_range("ss_ch3", int'(value_out[48 +: 16]), 4, 6);
    chk("ss_sat", 64'(sat), 64'd0);
    chk_range("model_ch0", m_raw[0], 24, 26);
    chk_range("model_ch3", m_raw[3], 4, 6);
    chk("small_ch0_sat_value", 64'(value_s[3:0]), 64'd15);
    chk("small_ch0_sat_bit", 64'(sat_s[0]), 64'd1);
    chk_range("small_ch3", int'(value_s[15:12]), 4, 6);
    #1 ready = 1'b1;
    tick();
    ready = 1'b0;
    @(negedge clk);
    chk("ss_valid_cleared", 64'(valid), 64'd0);

    // gate_len = 0 behaves as 1.
    tick();
    gate_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("gl0_valid_t2", 64'(valid), 64'd0);
    @(negedge clk);
    chk("gl0_valid_t3", 64'(valid), 64'd1);
    chk("gl0_idle_t3", 64'(busy), 64'd0);
    #1 ready = 1'b1;
    tick();
    ready = 1'b0;

    // Continuous, ready high: one valid pulse every L+1 cycles.
    tick();
    gate_len = 16'd10;
    ready = 1'b1;
    mode = 1'b1;
    k = 0;
    while (valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("cont_first_valid", 64'(k < 40), 64'd1);
    pulses = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    chk("cont_pulse_count", 64'(pulses), 64'd10);
    chk("cont_overrun", 64'(overrun), 64'd0);

    // Continuous, ready low across several windows.
    #1 ready = 1'b0;
    repeat (36) @(negedge clk);
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("ovr_valid", 64'(valid), 64'd1);
    #1 mode = 1'b0;
    repeat (14) @(negedge clk);
    chk("ovr_idle", 64'(busy), 64'd0);
    #1 ready = 1'b1;
    @(negedge clk);
    chk("ovr_hs_valid", 64'(valid), 64'd0);
    chk("ovr_hs_overrun", 64'(overrun), 64'd0);
    #1 ready = 1'b0;

    // Abort mid-GATE.
    tick();
    gate_len = 16'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    #1 enable = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", 64'(busy), 64'd0);
    repeat (60) @(negedge clk);
    chk("abort_no_valid", 64'(valid), 64'd0);
    #1 enable = 1'b1;

    // Reset asserted mid-window clears outputs immediately.
    tick();
    gate_len = 16'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_valid", 64'(valid), 64'd0);
    chk("rst_mid_value", value_out, 64'd0);
    chk("rst_mid_sat", 64'(sat), 64'd0);
    chk("rst_mid_value_s", 64'(value_s), 64'd0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int s = 0; s < 40; s++) begin
      tick();
      for (int ch = 0; ch < N_CH; ch++) begin
        hi_len[ch] = $urandom_range(1, 6);
        lo_len[ch] = $urandom_range(1, 6);
      end
      gate_len = 16'($urandom_range(0, 40));
      mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < 60; c++) begin
        tick();
        start  = ($urandom_range(0, 7) == 0);
        ready  = ($urandom_range(0, 2) == 0);
        enable = ($urandom_range(0, 29) != 0);
        if ($urandom_range(0, 19) == 0) mode = ~mode;
        if ($urandom_range(0, 15) == 0) gate_len = 16'($urandom_range(0, 40));
      end
    end

    tick();
    enable = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Multi-channel, parametrised ring-oscillator frequency meter; successor to the single-channel counting circuit. Samples N_CH asynchronous ring outputs into the system clock domain, counts rising edges over a programmable gate window, and delivers per-channel counts through a valid/ready result port. Supports single-shot and continuous measurement, with saturation and overrun reporting. Sits between the ring-oscillator array and the display/readout logic.

## Interface
- N_CH, 4, number of ring channels (≥1)
- CNT_W, 16, per-channel edge-count width
- GATE_W, 16, gate-length field width
- clk  in  1  system clock; sole clock of the block
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; low aborts any window
- start  in  1  single-shot trigger, one-cycle pulse
- mode  in  1  0 = single-shot, 1 = continuous
- gate_len  in  GATE_W  window length in clk cycles; 0 treated as 1
- ring_in  in  N_CH  asynchronous ring outputs
- busy  out  1  high while a window is in progress
- value_out  out  N_CH*CNT_W  captured counts, channel i at bits [i*CNT_W +: CNT_W]
- sat  out  N_CH  per-channel saturation flag of the captured result
- valid  out  1  result available
- ready  in  1  consumer accepts result
- overrun  out  1  sticky: an unaccepted result was overwritten

## Operation
- Each ring_in bit: 2-FF synchronizer, then rising-edge detect producing a one-cycle pulse.
- FSM states: IDLE, GATE, CAPTURE.
- IDLE -> GATE when enable=1 and (start=1 or mode=1). gate_len latched as L = max(gate_len,1); gate counter and all channel counters cleared.
- GATE: per cycle, each channel's edge pulse increments its counter; at all-ones the counter holds and its sat bit sets. After exactly L GATE cycles -> CAPTURE.
- CAPTURE (one cycle): counters and sat bits copied to value_out/sat; valid set. Then -> GATE (mode=1 and enable=1, new L latched) or IDLE.
- start ignored outside IDLE. mode changes take effect at the next IDLE/CAPTURE decision.
- enable=0 in any state: next state IDLE, counters cleared, no capture; value_out, sat, valid, overrun retained.
- Handshake: valid held until valid&ready; then valid clears next cycle. value_out stable while valid=1 except on overwrite.
- Capture while valid=1 and ready=0: value_out overwritten, valid stays 1, overrun set. Capture in same cycle as valid&ready: new result taken, overrun unchanged.
- overrun clears on valid&ready handshake not coincident with a capture, or on a start pulse accepted in IDLE.
- Reset: state IDLE; busy, valid, overrun, sat, value_out, counters, synchronizers all 0.

## Timing
- Ring edge to edge pulse: 3 clk cycles (2 sync + detect register).
- Edges are counted iff their edge pulse lands in a GATE cycle.
- start at cycle t: GATE cycles t+1..t+L; CAPTURE at t+L+1; valid=1 and value_out valid from t+L+2.
- busy high in GATE and CAPTURE.
- Continuous mode: period L+1 cycles; one-cycle dead time (CAPTURE) per window.
- Input edges measured correctly only for ring high/low phases each ≥ 1 clk period (f_ring < f_clk/2).

## Structure
- Package ring_meter_pkg: FSM state enum (IDLE, GATE, CAPTURE), mode constants MODE_SINGLE=0, MODE_CONT=1.
- Sub-module edge_sync: 2-FF synchronizer plus rising-edge detector for one bit, instantiated N_CH times via generate.
- Top holds FSM, gate counter, channel counters, result register, handshake.

## Test plan
- Single-shot, N_CH=4, gate_len=100, ring periods 4/8/10/20 clk -> valid at t+102, value_out = {5,10,12,25} per channel (±1), sat=0.
- CNT_W=4, gate_len=100, ring period 4 -> channel count 15, sat bit 1.
- Continuous, gate_len=10, ready tied high -> valid pulse every 11 cycles, overrun stays 0.
- Continuous, ready held 0 for 3 windows -> value_out tracks latest window, overrun=1; one ready pulse -> valid=0, overrun=0.
- enable dropped mid-GATE -> next cycle IDLE, busy=0, no new valid, previous value_out unchanged.
- gate_len=0 -> treated as 1: valid at t+3; rst_n asserted mid-window -> all outputs 0 immediately.
